// File: rtl/an_sec_decoder_seq.sv
// an_sec_decoder_seq: sequential AN-code single-error-correcting decoder.
// A received codeword W = A*N +/- 2^k is divided by A with a bit-serial
// restoring divider. A non-zero residue r is then matched against +/-(2^k mod A)
// one k per cycle, and the quotient is corrected by the matching 2^k div A term.
// Handshaked on both sides: one codeword in flight, result held until accepted.
// Optional macro AN_SEC_STATS_EN adds saturating corrected/uncorrectable
// counters (cnt_corr, cnt_uncorr) with a synchronous clear input (stats_clr).
module an_sec_decoder_seq #(
    parameter int A      = 83,
    parameter int A_BITS = 7,
    parameter int W_BITS = 36,
    parameter int N_BITS = 29,
    parameter int K_MAX  = 41,
    localparam int POS_W = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] in_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_n,
    output logic              out_err,
    output logic              out_sign,
    output logic [POS_W-1:0]  out_pos,
`ifdef AN_SEC_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       cnt_corr,
    output logic [15:0]       cnt_uncorr,
`endif
    output logic              out_uncorr
);

    localparam int CNT_W = $clog2(W_BITS + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(W_BITS - 1);
    localparam logic [A_BITS:0]   A_X      = (A_BITS + 1)'(A);
    localparam logic [POS_W-1:0]  K_LAST   = POS_W'(K_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIV  = 3'd1,
        S_CHK  = 3'd2,
        S_SRCH = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [W_BITS-1:0]   w_q, w_d;        // dividend, shifted out MSB first
    logic [N_BITS-1:0]   q_q, q_d;        // quotient, only the low N_BITS kept
    logic [A_BITS-1:0]   rem_q, rem_d;    // partial remainder / final residue
    logic [CNT_W-1:0]    cnt_q, cnt_d;    // division step counter
    logic [A_BITS-1:0]   p_q, p_d;        // 2^k mod A
    logic [W_BITS-1:0]   m_q, m_d;        // 2^k div A
    logic [POS_W-1:0]    k_q, k_d;        // current error position under test
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [N_BITS-1:0]   out_n_q, out_n_d;
    logic                out_err_q, out_err_d;
    logic                out_sign_q, out_sign_d;
    logic [POS_W-1:0]    out_pos_q, out_pos_d;
    logic                out_uncorr_q, out_uncorr_d;
`ifdef AN_SEC_STATS_EN
    logic [15:0]         cnt_corr_q, cnt_corr_d;
    logic [15:0]         cnt_uncorr_q, cnt_uncorr_d;
`endif

    // Restoring division step: shift in the next dividend bit, subtract A if it fits.
    logic [A_BITS:0]     rem_sh_s;
    logic                div_ge_s;
    logic [A_BITS-1:0]   rem_diff_s;
    logic [A_BITS-1:0]   rem_nx_s;

    assign rem_sh_s   = {rem_q, w_q[W_BITS-1]};
    assign div_ge_s   = (rem_sh_s >= A_X);
    assign rem_diff_s = rem_sh_s[A_BITS-1:0] - A_X[A_BITS-1:0];
    assign rem_nx_s   = div_ge_s ? rem_diff_s : rem_sh_s[A_BITS-1:0];

    // Residue search terms: hit tests and the doubling step for 2^(k+1).
    logic                pos_hit_s;
    logic                neg_hit_s;
    logic [A_BITS:0]     p2_s;
    logic                p2_ge_s;
    logic [A_BITS-1:0]   p_sub_s;

    assign pos_hit_s = (rem_q == p_q);
    assign neg_hit_s = (({1'b0, rem_q} + {1'b0, p_q}) == A_X);
    assign p2_s      = {p_q, 1'b0};
    assign p2_ge_s   = (p2_s >= A_X);
    assign p_sub_s   = p2_s[A_BITS-1:0] - A_X[A_BITS-1:0];

    // Corrected-operand candidates in W_BITS+1 bits with range checks.
    logic [W_BITS:0]     q_x_s;
    logic [W_BITS:0]     m_x_s;
    logic [W_BITS:0]     sub_s;
    logic [W_BITS:0]     add_s;
    logic                sub_ok_s;
    logic                add_ok_s;

    assign q_x_s    = {(W_BITS + 1 - N_BITS)'(0), q_q};
    assign m_x_s    = {1'b0, m_q};
    assign sub_s    = q_x_s - m_x_s;
    assign add_s    = q_x_s + m_x_s + (W_BITS + 1)'(1);
    assign sub_ok_s = (m_x_s <= q_x_s) && (sub_s[W_BITS:N_BITS] == '0);
    assign add_ok_s = (add_s[W_BITS:N_BITS] == '0);

    // Next-state and next-output computation for the decoder FSM.
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        q_d          = q_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        m_d          = m_q;
        k_d          = k_q;
        out_valid_d  = out_valid_q;
        out_n_d      = out_n_q;
        out_err_d    = out_err_q;
        out_sign_d   = out_sign_q;
        out_pos_d    = out_pos_q;
        out_uncorr_d = out_uncorr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    w_d     = in_w;
                    q_d     = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    p_d     = '0;
                    m_d     = '0;
                    k_d     = '0;
                    state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                w_d   = {w_q[W_BITS-2:0], 1'b0};
                q_d   = {q_q[N_BITS-2:0], div_ge_s};
                rem_d = rem_nx_s;
                if (cnt_q == DIV_LAST) begin
                    state_d = S_CHK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHK: begin
                if (rem_q == '0) begin
                    out_n_d      = q_q;
                    out_err_d    = 1'b0;
                    out_sign_d   = 1'b0;
                    out_pos_d    = '0;
                    out_uncorr_d = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    p_d     = A_BITS'(1);
                    m_d     = '0;
                    k_d     = '0;
                    state_d = S_SRCH;
                end
            end
            S_SRCH: begin
                if (pos_hit_s || neg_hit_s) begin
                    // A hit whose corrected value falls outside N_BITS is reported as uncorrectable.
                    if (pos_hit_s ? sub_ok_s : add_ok_s) begin
                        out_n_d      = pos_hit_s ? sub_s[N_BITS-1:0] : add_s[N_BITS-1:0];
                        out_err_d    = 1'b1;
                        out_sign_d   = !pos_hit_s;
                        out_pos_d    = k_q;
                        out_uncorr_d = 1'b0;
                    end else begin
                        out_n_d      = q_q;
                        out_err_d    = 1'b0;
                        out_sign_d   = 1'b0;
                        out_pos_d    = '0;
                        out_uncorr_d = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (k_q == K_LAST) begin
                    out_n_d      = q_q;
                    out_err_d    = 1'b0;
                    out_sign_d   = 1'b0;
                    out_pos_d    = '0;
                    out_uncorr_d = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    p_d = p2_ge_s ? p_sub_s : p2_s[A_BITS-1:0];
                    m_d = {m_q[W_BITS-2:0], p2_ge_s};
                    k_d = k_q + POS_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

`ifdef AN_SEC_STATS_EN
    // Saturating diagnostics counters; a clear overrides a same-cycle increment.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (stats_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_err_q && (cnt_corr_q != 16'hFFFF)) begin
                cnt_corr_d = cnt_corr_q + 16'd1;
            end else begin
                cnt_corr_d = cnt_corr_q;
            end
            if (out_uncorr_q && (cnt_uncorr_q != 16'hFFFF)) begin
                cnt_uncorr_d = cnt_uncorr_q + 16'd1;
            end else begin
                cnt_uncorr_d = cnt_uncorr_q;
            end
        end else begin
            cnt_corr_d   = cnt_corr_q;
            cnt_uncorr_d = cnt_uncorr_q;
        end
    end
`endif

    // State and registered outputs; asynchronous reset aborts any decode in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            q_q          <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            m_q          <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_n_q      <= '0;
            out_err_q    <= 1'b0;
            out_sign_q   <= 1'b0;
            out_pos_q    <= '0;
            out_uncorr_q <= 1'b0;
`ifdef AN_SEC_STATS_EN
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            q_q          <= q_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            p_q          <= p_d;
            m_q          <= m_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_n_q      <= out_n_d;
            out_err_q    <= out_err_d;
            out_sign_q   <= out_sign_d;
            out_pos_q    <= out_pos_d;
            out_uncorr_q <= out_uncorr_d;
`ifdef AN_SEC_STATS_EN
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_n      = out_n_q;
    assign out_err    = out_err_q;
    assign out_sign   = out_sign_q;
    assign out_pos    = out_pos_q;
    assign out_uncorr = out_uncorr_q;
`ifdef AN_SEC_STATS_EN
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Directed testbench for an_sec_decoder_seq: default build (A=83, W=36) plus a
// small A=31, W=16, K_MAX=5 instance for the uncorrectable path.
module tb_an_sec_decoder_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Instance 1: default parameters
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [35:0] in_w1;
    logic [28:0] out_n1;
    logic        out_err1, out_sign1, out_uncorr1;
    logic [5:0]  out_pos1;
`ifdef AN_SEC_STATS_EN
    logic        stats_clr;
    logic [15:0] cnt_corr, cnt_uncorr;
`endif

    // Instance 2: A=31 small configuration
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] in_w2;
    logic [10:0] out_n2;
    logic        out_err2, out_sign2, out_uncorr2;
    logic [2:0]  out_pos2;

    an_sec_decoder_seq dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_w       (in_w1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_n      (out_n1),
        .out_err    (out_err1),
        .out_sign   (out_sign1),
        .out_pos    (out_pos1),
`ifdef AN_SEC_STATS_EN
        .stats_clr  (stats_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr),
`endif
        .out_uncorr (out_uncorr1)
    );

    an_sec_decoder_seq #(
        .A      (31),
        .A_BITS (5),
        .W_BITS (16),
        .N_BITS (11),
        .K_MAX  (5)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_w       (in_w2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_n      (out_n2),
        .out_err    (out_err2),
        .out_sign   (out_sign2),
        .out_pos    (out_pos2),
`ifdef AN_SEC_STATS_EN
        .stats_clr  (1'b0),
        .cnt_corr   (),
        .cnt_uncorr (),
`endif
        .out_uncorr (out_uncorr2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for idle, hand over one codeword to dut1 and count edges to out_valid.
    task automatic dec1(input logic [35:0] w, output int lat);
        int guard = 0;
        while (!in_ready1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready1) check("dut1_idle_timeout", 64'd0, 64'd1);
        in_w1 = w; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_w1 = '1;
        lat = 0;
        while (!out_valid1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid1) check("dut1_out_timeout", 64'd0, 64'd1);
    endtask

    task automatic ack1();
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("dut1_valid_drop", 64'(out_valid1), 64'd0);
        check("dut1_ready_back", 64'(in_ready1), 64'd1);
    endtask

    task automatic vec1(input string tag, input logic [35:0] w, input logic [28:0] n,
                        input logic err, input logic sgn, input logic [5:0] pos,
                        input logic unc, input int lat_exp);
        int lat;
        dec1(w, lat);
        check({tag, "_n"},      64'(out_n1),      64'(n));
        check({tag, "_err"},    64'(out_err1),    64'(err));
        check({tag, "_sign"},   64'(out_sign1),   64'(sgn));
        check({tag, "_pos"},    64'(out_pos1),    64'(pos));
        check({tag, "_uncorr"}, 64'(out_uncorr1), 64'(unc));
        check({tag, "_lat"},    64'(lat),         64'(lat_exp));
        ack1();
    endtask

    task automatic vec2(input string tag, input logic [15:0] w, input logic [10:0] n,
                        input logic err, input logic unc, input int lat_exp);
        int lat;
        int guard = 0;
        while (!in_ready2 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready2) check("dut2_idle_timeout", 64'd0, 64'd1);
        in_w2 = w; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid2) check("dut2_out_timeout", 64'd0, 64'd1);
        check({tag, "_n"},      64'(out_n2),      64'(n));
        check({tag, "_err"},    64'(out_err2),    64'(err));
        check({tag, "_uncorr"}, 64'(out_uncorr2), 64'(unc));
        check({tag, "_lat"},    64'(lat),         64'(lat_exp));
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check({tag, "_ready_back"}, 64'(in_ready2), 64'd1);
    endtask

    initial begin
        int lat;
        logic [28:0] held_n;
        logic        stable_ok;
        logic        ready_low_ok;
        logic        seen_valid;

        rst_n = 1'b0;
        in_valid1 = 1'b0; in_w1 = '0; out_ready1 = 1'b0;
        in_valid2 = 1'b0; in_w2 = '0; out_ready2 = 1'b0;
`ifdef AN_SEC_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_out_n",     64'(out_n1),     64'd0);
        check("rst_out_err",   64'(out_err1),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready1), 64'd1);

        // Default build vectors: codeword, expected N, err, sign, pos, uncorr, latency
        vec1("clean",     36'd83000,       29'd1000,      1'b0, 1'b0, 6'd0,  1'b0, 37);
        vec1("pos_k3",    36'd83008,       29'd1000,      1'b1, 1'b0, 6'd3,  1'b0, 41);
        vec1("neg_k0",    36'd82999,       29'd1000,      1'b1, 1'b1, 6'd0,  1'b0, 38);
        vec1("pos_k10",   36'd84024,       29'd1000,      1'b1, 1'b0, 6'd10, 1'b0, 48);
        vec1("neg_k5",    36'd82968,       29'd1000,      1'b1, 1'b1, 6'd5,  1'b0, 43);
        vec1("clean_big", 36'd1024635,     29'd12345,     1'b0, 1'b0, 6'd0,  1'b0, 37);
        vec1("zero",      36'd0,           29'd0,         1'b0, 1'b0, 6'd0,  1'b0, 37);
        vec1("under",     36'd28,          29'd0,         1'b0, 1'b0, 6'd0,  1'b1, 48);
        vec1("over",      36'd44560285695, 29'd536870911, 1'b0, 1'b0, 6'd0,  1'b1, 38);

        // Small configuration: residue 3 never matches +/-2^k mod 31 for k<5
        vec2("a31_uncorr", 16'd313,  11'd10,  1'b0, 1'b1, 22);
        vec2("a31_clean",  16'd3100, 11'd100, 1'b0, 1'b0, 17);

        // Back-pressure: outputs held while out_ready is low
        dec1(36'd83008, lat);
        held_n = out_n1;
        stable_ok = 1'b1;
        ready_low_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_valid1 || out_n1 !== held_n || !out_err1 || out_pos1 !== 6'd3) stable_ok = 1'b0;
            if (in_ready1) ready_low_ok = 1'b0;
        end
        check("hold_stable",    64'(stable_ok),    64'd1);
        check("hold_ready_low", 64'(ready_low_ok), 64'd1);
        check("hold_n",         64'(out_n1),       64'd1000);
        ack1();

`ifdef AN_SEC_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        check("stats_clr_corr",   64'(cnt_corr),   64'd0);
        check("stats_clr_uncorr", 64'(cnt_uncorr), 64'd0);
        vec1("st_a", 36'd83008, 29'd1000, 1'b1, 1'b0, 6'd3,  1'b0, 41);
        vec1("st_b", 36'd82999, 29'd1000, 1'b1, 1'b1, 6'd0,  1'b0, 38);
        vec1("st_c", 36'd84024, 29'd1000, 1'b1, 1'b0, 6'd10, 1'b0, 48);
        vec1("st_d", 36'd28,    29'd0,    1'b0, 1'b0, 6'd0,  1'b1, 48);
        check("stats_corr_3",   64'(cnt_corr),   64'd3);
        check("stats_uncorr_1", 64'(cnt_uncorr), 64'd1);
        dec1(36'd83008, lat);
        stats_clr = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        out_ready1 = 1'b0;
        check("stats_clr_wins_corr",   64'(cnt_corr),   64'd0);
        check("stats_clr_wins_uncorr", 64'(cnt_uncorr), 64'd0);
`endif

        // Reset during the residue search: no result may ever appear
        while (!in_ready1) begin
            @(posedge clk); #1;
        end
        in_w1 = 36'd28; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid1) seen_valid = 1'b1;
        end
        check("abort_no_valid",  64'(seen_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready1),  64'd1);

        // Decoder still works after the aborted operation
        vec1("post_rst", 36'd83000, 29'd1000, 1'b0, 1'b0, 6'd0, 1'b0, 37);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
